// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: types and constants shared by the USB-style TX/RX serial path
package usb_tx_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, STUFF} bts_state_t;
    // The RX bit-stuff decoder must use the same run length
    localparam int STUFF_LEN = 6;
endpackage

// File: rtl/encode_bts.sv
// encode_bts: transmit bit-stuffing encoder, inserts a 0 after a run of STUFF_LEN ones
module encode_bts
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LEN = usb_tx_pkg::STUFF_LEN,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_enable,
    input  logic             tx_active,
    input  logic             data_in,
    output logic             data_out,
    output logic             EncodeSREnable,
    output logic             busy,
    output logic [CNT_W-1:0] stuff_cnt
);
    localparam int OW = $clog2(STUFF_LEN + 1);

    bts_state_t       state_q, state_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;

    // Next-state and output decode; the stuffed 0 blocks the shift register for one strobe
    always_comb begin
        state_d        = state_q;
        ones_d         = ones_q;
        stuff_cnt_d    = stuff_cnt_q;
        data_out       = data_in;
        EncodeSREnable = shift_enable;
        busy           = state_q != IDLE;
        unique case (state_q)
            IDLE: begin
                if (tx_active) begin
                    state_d     = COUNT;
                    ones_d      = '0;
                    stuff_cnt_d = '0;
                end
            end
            COUNT: begin
                if (!tx_active) begin
                    state_d = IDLE;
                    ones_d  = '0;
                end else if (shift_enable) begin
                    if (!data_in) ones_d = '0;
                    else if (ones_q == OW'(STUFF_LEN - 1)) begin
                        state_d = STUFF;
                        ones_d  = '0;
                    end else ones_d = ones_q + 1'b1;
                end
            end
            STUFF: begin
                data_out       = 1'b0;
                EncodeSREnable = 1'b0;
                if (shift_enable) begin
                    stuff_cnt_d = &stuff_cnt_q ? stuff_cnt_q : stuff_cnt_q + 1'b1;
                    ones_d      = '0;
                    state_d     = tx_active ? COUNT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, run counter and stuffed-bit counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ones_q      <= '0;
            stuff_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            stuff_cnt_q <= stuff_cnt_d;
        end
    end

    assign stuff_cnt = stuff_cnt_q;
endmodule

// File: doc/encode_bts.md
Name: encode_bts

Overview:
- Transmit-side bit-stuffing encoder for the USB-style serial link.
- Sits between the TX parallel-to-serial shift register and the NRZI encoder.
- Counts consecutive transmitted 1s. After STUFF_LEN of them, inserts one 0 bit.
- While the stuffed 0 is sent, it holds the upstream shift register by gating its shift enable.

Parameters:
- STUFF_LEN, 6: consecutive 1s that trigger insertion of one 0; legal range 2..15.
- CNT_W, 8: width of the per-packet stuffed-bit counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- shift_enable  input  1  one-cycle bit-period strobe from the TX bit timer.
- tx_active  input  1  high for the duration of a packet, from the TX controller.
- data_in  input  1  current serial bit from the TX shift register.
- data_out  output  1  bit to NRZI encoder; combinational.
- EncodeSREnable  output  1  gated shift enable to the TX shift register; combinational.
- busy  output  1  high while in COUNT or STUFF; the TX controller must not end the packet while busy.
- stuff_cnt  output  CNT_W  number of bits stuffed in the current/last packet; saturating.

Behaviour:
- States (enum): IDLE, COUNT, STUFF. ones counter has width $clog2(STUFF_LEN+1).
- Reset (rst sampled high on a clk edge):
  - state=IDLE, ones=0, stuff_cnt=0.
  - Outputs after reset: data_out=data_in, EncodeSREnable=shift_enable, busy=0.
  - rst has priority over every other input, including mid-STUFF.
- Output decode:
  - IDLE/COUNT: data_out=data_in, EncodeSREnable=shift_enable.
  - STUFF: data_out=0, EncodeSREnable=0.
  - busy = (state!=IDLE).
- IDLE:
  - shift_enable ignored.
  - tx_active=1 -> COUNT next cycle, ones=0, stuff_cnt=0.
  - A shift_enable in the same cycle as the tx_active rise is not counted.
- COUNT, shift_enable=1:
  - data_in=1 and ones==STUFF_LEN-1 -> STUFF, ones=0.
  - data_in=1 otherwise -> ones+1.
  - data_in=0 -> ones=0.
- COUNT, shift_enable=0: hold state and ones.
- COUNT, tx_active=0: -> IDLE, ones=0. A same-cycle shift_enable bit is treated as the last bit and not counted.
- STUFF:
  - Waits for the next shift_enable. That strobe transmits the stuffed 0 and is blocked from the shift register.
  - On that strobe: stuff_cnt+1 (saturate at all-ones), ones=0, next state COUNT if tx_active=1 else IDLE.
  - tx_active falling while in STUFF does not abort. The stuffed 0 is still sent and busy stays 1 until that strobe completes.
- Latency: zero-cycle combinational path data_in->data_out. The state change lands on the clock edge of the qualifying strobe.
- Insertion rules:
  - The stuffed 0 resets the run, so 12 consecutive 1s produce exactly 2 insertions.
  - A 0 in the data immediately after six 1s is still preceded by a stuffed 0, giving two 0s on the line.
- stuff_cnt holds its value in IDLE; it is cleared only on entry to COUNT or on reset.

Decomposition:
- Shared package usb_tx_pkg holds:
  - typedef enum logic [1:0] bts_state_t {IDLE, COUNT, STUFF};
  - localparam default STUFF_LEN=6 (the RX decoder uses the same value).
- No sub-module; single flat module with one state register, one ones counter and one stuff_cnt register.

Test Plan:
- Reset, then tx_active=1 and strobes every 8 clks with data_in=1 for 8 bits:
  - data_out=1 for 6 strobes, then data_out=0 with EncodeSREnable=0 on the 7th strobe.
  - The remaining two 1s follow; stuff_cnt=1.
- Send bits 0111_1110 (LSB first) -> 6 ones then a stuffed 0 then the data 0; line sequence 0,1,1,1,1,1,1,0,0; stuff_cnt=1.
- 12 consecutive 1s -> stuffed 0 after bit 6 and after bit 12; EncodeSREnable gated on exactly 2 strobes; stuff_cnt=2.
- Six 1s then tx_active drops before the next strobe:
  - busy stays 1 and data_out=0 on the next strobe.
  - Then IDLE, busy=0, stuff_cnt=1.
- Five 1s, a 0, then six 1s -> no stuff after the first run, one stuff after the second; ones resets on the 0.
- Assert rst while in STUFF -> next cycle state IDLE, data_out follows data_in, EncodeSREnable follows shift_enable, stuff_cnt=0, busy=0.
